csr_pwm_bank: RTL
=================

Name: csr_pwm_bank

Overview:
- Byte-serial CSR register file plus an N-channel PWM engine and GPIO output port, sitting behind the SPI slave byte interface.
- Generalises the single-channel GPIO/PWM control block:
  - parametrised channel count and counter width;
  - shared programmable period;
  - per-channel duty registers, double-buffered at the period boundary;
  - explicit read-back handshake;
  - framed command/data byte protocol.

Parameters:
- N_CH, 4, number of PWM channels (1..8); channel i drives out[i].
- CNT_W, 16, PWM counter width (9..16); period and duty are CNT_W bits.
- DEPTH, 32, CSR byte locations implemented; must be >= 8+2*N_CH.
- ADDR_WIDTH, 6, address field width in the command byte; fixed by the byte format.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rx_data  in  8  byte from SPI slave.
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle.
- frame_start  in  1  one-cycle pulse on chip-select assertion; resynchronises the protocol FSM.
- tx_data  out  8  read-back byte to SPI slave.
- tx_valid  out  1  one-cycle strobe; tx_data is valid.
- out  out  8  registered GPIO/PWM pins.

Behaviour:
- Reset values:
  - all CSRs 0, except ID, which is read-only 8'h02;
  - counter 0, active period/duty registers 0;
  - tx_data 0, tx_valid 0, out 0;
  - FSM in CMD.
- Command byte = {op[1:0], addr[5:0]}:
  - op 2'b10: write;
  - op 2'b01: read;
  - op 2'b00 and 2'b11: NOP, FSM stays in CMD.
- FSM states: CMD, WDATA.
  - CMD + rx_valid + write: latch addr, go to WDATA.
  - CMD + rx_valid + read: on the next edge tx_data <= csr[addr] and tx_valid = 1 for exactly one cycle; stay in CMD.
  - WDATA + rx_valid: on the next edge csr[addr] <= rx_data; return to CMD.
- Latency: written value is readable and affects logic from the cycle after the write edge. Read data appears 1 cycle after the command strobe.
- frame_start forces CMD, dropping any pending write. If frame_start and rx_valid coincide, the byte is decoded as a command.
- Address rules:
  - addr >= DEPTH: writes ignored, reads return 8'h00 with tx_valid still pulsed.
  - Writes to ID are ignored.
- Register map:
  - 0x00 CTRL: bit0 gpio_en, bit1 pwm_run, bit2 cnt_clr. cnt_clr is self-clearing and always reads 0.
  - 0x01 CH_EN: bit i enables channel i; bits >= N_CH read 0.
  - 0x02 PERIOD_H, 0x03 PERIOD_L.
  - 0x04 GPIO_OUT.
  - 0x05 ID.
  - 0x08+2i DUTY_H[i], 0x09+2i DUTY_L[i].
  - All other addresses below DEPTH: plain R/W scratch.
- Width rule: 16-bit values are {H,L} truncated to CNT_W LSBs. Unused H bits remain readable as written.
- Counter:
  - Holds when pwm_run = 0.
  - When pwm_run = 1: if counter == period_act, counter <= 0 (wrap); else counter + 1. PWM period is period_act+1 clocks.
  - cnt_clr write: counter <= 0 on the write edge. cnt_clr takes priority over increment.
- Shadowing: period_act and duty_act[i] load from their CSRs on the wrap edge, or on every cycle while pwm_run = 0. A mid-period duty write never produces a glitch pulse.
- Compare: pwm[i] = (counter < duty_act[i]).
  - duty 0: constant 0.
  - duty > period_act: constant 1.
  - period_act 0: counter stays 0; pwm[i] = (duty != 0).
- Output mux, registered (1-cycle delay):
  - out[i] = pwm[i] when i < N_CH, pwm_run and ch_en[i];
  - else out[i] = gpio_out[i] when gpio_en;
  - else 0.
- Reset mid-transaction: FSM returns to CMD and a partial write is discarded. All state returns to reset values on the same edge.

Decomposition:
- Package csr_pwm_pkg:
  - opcode constants OP_WR/OP_RD;
  - register address constants (CTRL, CH_EN, PERIOD_H/L, GPIO_OUT, ID, DUTY_BASE);
  - ID value;
  - FSM state enum.
- Sub-module pwm_channel (one per channel):
  - inputs: duty CSR, counter, load strobe;
  - contents: duty_act shadow register and comparator;
  - output: pwm bit.
- Top level: FSM, CSR array, counter, output mux.

Test Plan:
- Reset, then read 0x05 -> tx_data 8'h02 with one-cycle tx_valid; read 0x00 -> 8'h00. Read 0x3F -> 8'h00 with tx_valid.
- Write GPIO_OUT = 8'hA5, then CTRL = 8'h01 -> out == 8'hA5 two cycles after the CTRL data strobe. With gpio_en = 0 -> out == 0.
- PERIOD = 9, DUTY0 = 3, CH_EN = 1, CTRL = 8'h02 -> out[0] high 3 of every 10 clocks. DUTY0 = 0 -> constant 0. DUTY0 = 12 -> constant 1.
- Change DUTY0 from 3 to 7 at counter = 5 -> current period keeps width 3; next period has width 7 with no extra edges.
- Write command, then frame_start before the data byte -> no CSR change; the next byte is decoded as a command. Same check with rst asserted between the command and data bytes.
- CTRL = 8'h06 while running at counter = 6 -> counter 0 next cycle; CTRL reads back 8'h02. NOP command (op 2'b11) -> no tx_valid, FSM stays in CMD.

Source files
------------

// File: rtl/csr_pwm_pkg.sv
// rtl/csr_pwm_pkg.sv - shared opcodes, register map and FSM states for the CSR/PWM bank
package csr_pwm_pkg;

   localparam logic [1:0] OP_WR = 2'b10;
   localparam logic [1:0] OP_RD = 2'b01;

   localparam logic [5:0] A_CTRL      = 6'h00;
   localparam logic [5:0] A_CH_EN     = 6'h01;
   localparam logic [5:0] A_PERIOD_H  = 6'h02;
   localparam logic [5:0] A_PERIOD_L  = 6'h03;
   localparam logic [5:0] A_GPIO_OUT  = 6'h04;
   localparam logic [5:0] A_ID        = 6'h05;
   localparam logic [5:0] A_DUTY_BASE = 6'h08;

   localparam logic [7:0] ID_VALUE      = 8'h02;
   localparam logic [7:0] CTRL_STORE_MASK = 8'hFB;

   typedef enum logic {ST_CMD, ST_WDATA} state_t;

endpackage

// File: rtl/csr_pwm_bank_pwm_channel.sv
// rtl/csr_pwm_bank_pwm_channel.sv - one PWM channel: shadowed duty register and comparator
module pwm_channel
   import csr_pwm_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] duty_csr,
   input  logic [CNT_W-1:0] counter,
   output logic             pwm
);

   logic [CNT_W-1:0] duty_act;

   // Shadow only moves at the period boundary, so a mid-period write cannot glitch.
   always_ff @(posedge clk) begin
      if (rst)
         duty_act <= '0;
      else if (load)
         duty_act <= duty_csr;
   end

   assign pwm = (counter < duty_act);

endmodule

// File: rtl/csr_pwm_bank.sv
// rtl/csr_pwm_bank.sv - byte-serial CSR file with N-channel PWM engine and GPIO port
module csr_pwm_bank
   import csr_pwm_pkg::*;
#(
   parameter int N_CH       = 4,
   parameter int CNT_W      = 16,
   parameter int DEPTH      = 32,
   parameter int ADDR_WIDTH = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       frame_start,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   output logic [7:0] out
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [7:0] CH_MASK = 8'((16'd1 << N_CH) - 16'd1);

   logic [7:0]            csr [DEPTH];
   state_t                state, state_nx;
   logic [ADDR_WIDTH-1:0] addr_q, addr_nx;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [1:0]            op;
   logic                  wr_en, rd_en, wr_hit, cnt_clr;
   logic [7:0]            wdata, rd_byte;

   assign op       = rx_data[7:6];
   assign cmd_addr = rx_data[ADDR_WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_CMD;
         addr_q <= '0;
      end else begin
         state  <= state_nx;
         addr_q <= addr_nx;
      end
   end

   // frame_start overrides WDATA, so a coincident byte is decoded as a command.
   always_comb begin
      state_nx = state;
      addr_nx  = addr_q;
      wr_en    = 1'b0;
      rd_en    = 1'b0;
      if (frame_start)
         state_nx = ST_CMD;
      if (rx_valid) begin
         if (state == ST_WDATA && !frame_start) begin
            wr_en    = 1'b1;
            state_nx = ST_CMD;
         end else if (op == OP_WR) begin
            addr_nx  = cmd_addr;
            state_nx = ST_WDATA;
         end else if (op == OP_RD) begin
            rd_en = 1'b1;
         end
      end
   end

   assign wr_hit  = wr_en && (int'(addr_q) < DEPTH) && (addr_q != A_ID);
   assign cnt_clr = wr_hit && (addr_q == A_CTRL) && rx_data[2];
   assign rd_byte = (int'(cmd_addr) < DEPTH) ? csr[cmd_addr[IDX_W-1:0]] : 8'h00;

   always_comb begin
      case (addr_q)
         A_CTRL:  wdata = rx_data & CTRL_STORE_MASK;
         A_CH_EN: wdata = rx_data & CH_MASK;
         default: wdata = rx_data;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            csr[i] <= (i == int'(A_ID)) ? ID_VALUE : 8'h00;
      end else if (wr_hit) begin
         csr[addr_q[IDX_W-1:0]] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_data  <= 8'h00;
         tx_valid <= 1'b0;
      end else begin
         tx_valid <= rd_en;
         if (rd_en)
            tx_data <= rd_byte;
      end
   end

   logic             gpio_en, pwm_run, wrap, load;
   logic [7:0]       ch_en, gpio_out, pwm, out_nx;
   logic [15:0]      period16;
   logic [CNT_W-1:0] period_act, counter;

   assign gpio_en  = csr[A_CTRL][0];
   assign pwm_run  = csr[A_CTRL][1];
   assign ch_en    = csr[A_CH_EN];
   assign gpio_out = csr[A_GPIO_OUT];
   assign period16 = {csr[A_PERIOD_H], csr[A_PERIOD_L]};
   assign wrap     = pwm_run && (counter == period_act);
   assign load     = !pwm_run || wrap;

   always_ff @(posedge clk) begin
      if (rst) begin
         counter    <= '0;
         period_act <= '0;
      end else begin
         if (cnt_clr || wrap)
            counter <= '0;
         else if (pwm_run)
            counter <= counter + 1'b1;
         if (load)
            period_act <= period16[CNT_W-1:0];
      end
   end

   for (genvar g = 0; g < 8; g++) begin : g_ch
      if (g < N_CH) begin : g_on
         logic [15:0] duty16;
         assign duty16 = {csr[int'(A_DUTY_BASE) + 2*g], csr[int'(A_DUTY_BASE) + 2*g + 1]};
         pwm_channel #(.CNT_W(CNT_W)) u_ch (
            .clk      (clk),
            .rst      (rst),
            .load     (load),
            .duty_csr (duty16[CNT_W-1:0]),
            .counter  (counter),
            .pwm      (pwm[g])
         );
      end else begin : g_off
         assign pwm[g] = 1'b0;
      end
   end

   // ch_en bits above N_CH are stored as 0, so they never select the PWM path.
   always_comb begin
      out_nx = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (pwm_run && ch_en[i])
            out_nx[i] = pwm[i];
         else if (gpio_en)
            out_nx[i] = gpio_out[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         out <= 8'h00;
      else
         out <= out_nx;
   end

endmodule
